// File: rtl/conv_ch_sequencer.sv
// Two-level (output group x input channel) convolution pass sequencer with programmable drain.
// Optional cycle/stall counters are built when CONV_SEQ_PERF_EN is defined.
module conv_ch_sequencer #(
    parameter int CH_W      = 7,
    parameter int OCH_W     = 4,
    parameter int DRAIN_CYC = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CH_W-1:0]  i_num_ch,
    input  logic [OCH_W-1:0] i_num_och,
    input  logic             i_w_ended,
    input  logic             i_pass_done,
    input  logic             i_abort,
    output logic             o_busy,
    output logic [CH_W-1:0]  o_ch_idx,
    output logic [OCH_W-1:0] o_och_idx,
    output logic             o_w_load_req,
    output logic             o_compute_en,
    output logic             o_load,
    output logic             o_done,
    output logic             o_err
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [31:0]      o_cycles,
    output logic [31:0]      o_stall
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_COMPUTE,
        S_NEXT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [3:0] DRAIN_LAST = (DRAIN_CYC == 0) ? 4'd0 : 4'(DRAIN_CYC - 1);

    state_t           state_q, state_d;
    logic [CH_W-1:0]  num_ch_q, num_ch_d;
    logic [OCH_W-1:0] num_och_q, num_och_d;
    logic [CH_W-1:0]  ch_idx_q, ch_idx_d;
    logic [OCH_W-1:0] och_idx_q, och_idx_d;
    logic [3:0]       drain_cnt_q, drain_cnt_d;
    logic             err_q, err_d;

    logic start_ok;
    logic abort_hit;
    logic ch_more;
    logic och_last;

    assign start_ok  = i_start && (i_num_ch != '0) && (i_num_och != '0);
    assign abort_hit = i_abort && (state_q != S_IDLE);
    // Terminal compares are done before incrementing so full-scale counts never wrap.
    assign ch_more   = ch_idx_q < num_ch_q;
    assign och_last  = och_idx_q == (num_och_q - OCH_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            num_ch_q    <= '0;
            num_och_q   <= '0;
            ch_idx_q    <= '0;
            och_idx_q   <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_ch_q    <= num_ch_d;
            num_och_q   <= num_och_d;
            ch_idx_q    <= ch_idx_d;
            och_idx_q   <= och_idx_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_hit) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (start_ok) state_d = S_WLOAD;
                S_WLOAD:   if (i_w_ended) state_d = S_COMPUTE;
                S_COMPUTE: if (i_pass_done) state_d = S_NEXT;
                S_NEXT: begin
                    if (ch_more || !och_last) state_d = S_WLOAD;
                    else if (DRAIN_CYC == 0)  state_d = S_DONE;
                    else                      state_d = S_DRAIN;
                end
                S_DRAIN:   if (drain_cnt_q == DRAIN_LAST) state_d = S_DONE;
                S_DONE:    state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        num_ch_d    = num_ch_q;
        num_och_d   = num_och_q;
        ch_idx_d    = ch_idx_q;
        och_idx_d   = och_idx_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = err_q;
        if (abort_hit) begin
            ch_idx_d  = '0;
            och_idx_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        num_ch_d  = i_num_ch;
                        num_och_d = i_num_och;
                        ch_idx_d  = CH_W'(1);
                        och_idx_d = '0;
                        err_d     = 1'b0;
                    end else if (i_start) begin
                        err_d = 1'b1;
                    end
                end
                S_NEXT: begin
                    drain_cnt_d = '0;
                    if (ch_more) begin
                        ch_idx_d = ch_idx_q + CH_W'(1);
                    end else if (!och_last) begin
                        ch_idx_d  = CH_W'(1);
                        och_idx_d = och_idx_q + OCH_W'(1);
                    end
                end
                S_DRAIN: drain_cnt_d = drain_cnt_q + 4'd1;
                S_DONE: begin
                    ch_idx_d  = '0;
                    och_idx_d = '0;
                end
                default: ;
            endcase
        end
        if ((i_w_ended && state_q != S_WLOAD) || (i_pass_done && state_q != S_COMPUTE)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        o_busy       = state_q != S_IDLE;
        o_w_load_req = state_q == S_WLOAD;
        o_compute_en = state_q == S_COMPUTE;
        o_load       = state_q == S_DONE;
        o_done       = state_q == S_DONE;
    end

    assign o_ch_idx  = ch_idx_q;
    assign o_och_idx = och_idx_q;
    assign o_err     = err_q;

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] stall_q, stall_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cycles_q <= '0;
            stall_q  <= '0;
        end else begin
            cycles_q <= cycles_d;
            stall_q  <= stall_d;
        end
    end

    // Counters saturate rather than wrap; they hold after o_done until the next accepted start.
    always_comb begin
        cycles_d = cycles_q;
        stall_d  = stall_q;
        if (state_q == S_IDLE && start_ok) begin
            cycles_d = '0;
            stall_d  = '0;
        end else begin
            if ((state_q == S_WLOAD || state_q == S_COMPUTE) && cycles_q != '1) begin
                cycles_d = cycles_q + 32'd1;
            end
            if (state_q == S_WLOAD && stall_q != '1) begin
                stall_d = stall_q + 32'd1;
            end
        end
    end

    assign o_cycles = cycles_q;
    assign o_stall  = stall_q;
`endif

endmodule

// File: tb/tb_conv_ch_sequencer.sv
// Scoreboard bench for conv_ch_sequencer: expected (och,ch) pairs are queued at start
// and popped on every rising o_w_load_req.
`timescale 1ns/1ps
module tb_conv_ch_sequencer;
    localparam int CH_W      = 7;
    localparam int OCH_W     = 4;
    localparam int DRAIN_CYC = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CH_W-1:0]  num_ch;
    logic [OCH_W-1:0] num_och;
    logic             w_ended;
    logic             pass_done;
    logic             abort;
    logic             busy;
    logic [CH_W-1:0]  ch_idx;
    logic [OCH_W-1:0] och_idx;
    logic             w_load_req;
    logic             compute_en;
    logic             load;
    logic             done;
    logic             err;
`ifdef CONV_SEQ_PERF_EN
    logic [31:0]      cycles;
    logic [31:0]      stall;
`endif

    always #5 clk = ~clk;

    conv_ch_sequencer #(
        .CH_W      (CH_W),
        .OCH_W     (OCH_W),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_num_ch     (num_ch),
        .i_num_och    (num_och),
        .i_w_ended    (w_ended),
        .i_pass_done  (pass_done),
        .i_abort      (abort),
        .o_busy       (busy),
        .o_ch_idx     (ch_idx),
        .o_och_idx    (och_idx),
        .o_w_load_req (w_load_req),
        .o_compute_en (compute_en),
        .o_load       (load),
        .o_done       (done),
        .o_err        (err)
`ifdef CONV_SEQ_PERF_EN
        ,
        .o_cycles     (cycles),
        .o_stall      (stall)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard of expected {och,ch} at each weight-load request.
    logic [OCH_W+CH_W-1:0] exp_q[$];
    logic [OCH_W+CH_W-1:0] exp_pair;
    int   rise_cnt = 0;
    logic req_prev = 1'b0;

    always @(negedge clk) begin
        if (w_load_req && !req_prev) begin
            rise_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_wload", 32'd1, 32'd0);
            end else begin
                exp_pair = exp_q.pop_front();
                check_eq("wload_idx", 32'({och_idx, ch_idx}), 32'(exp_pair));
            end
        end
        req_prev = w_load_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_idx"}, 32'({och_idx, ch_idx}), 32'd0);
        check_eq({tag, "_ctl"}, 32'({w_load_req, compute_en, load, done}), 32'd0);
    endtask

    task automatic start_layer(input int nch, input int noch);
        for (int o = 0; o < noch; o++)
            for (int c = 1; c <= nch; c++)
                exp_q.push_back({OCH_W'(o), CH_W'(c)});
        num_ch  = CH_W'(nch);
        num_och = OCH_W'(noch);
        start   = 1'b1;
        step();
        start   = 1'b0;
        check_eq("start_req", 32'({busy, w_load_req}), 32'd3);
    endtask

    // Entered in WLOAD; leaves the DUT in NEXT.
    task automatic do_pass(input int lat);
        repeat (lat) step();
        w_ended = 1'b1;
        step();
        w_ended = 1'b0;
        check_eq("compute_en", 32'({w_load_req, compute_en}), 32'd1);
        repeat (lat) step();
        pass_done = 1'b1;
        step();
        pass_done = 1'b0;
        check_eq("next_state", 32'({busy, w_load_req, compute_en}), 32'd4);
    endtask

    // Entered in the final NEXT; expects DONE exactly DRAIN_CYC+1 cycles later.
    task automatic finish_layer();
        int c = 0;
        do begin
            step();
            c++;
        end while (!done && c < 40);
        check_eq("done_latency", 32'(c), 32'(DRAIN_CYC + 1));
        check_eq("load_with_done", 32'(load), 32'd1);
        step();
        check_idle("post_done");
    endtask

    task automatic run_layer(input int nch, input int noch, input int lat);
        int r0 = rise_cnt;
        int n  = nch * noch;
        start_layer(nch, noch);
        for (int p = 0; p < n; p++) begin
            do_pass(lat);
            if (p != n - 1) begin
                step();
                check_eq("wload_again", 32'(w_load_req), 32'd1);
            end
        end
        finish_layer();
        check_eq("wload_rises", 32'(rise_cnt - r0), 32'(n));
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef CONV_SEQ_PERF_EN
        check_eq("perf_cycles", cycles, 32'(n * 2 * (lat + 1)));
        check_eq("perf_stall", stall, 32'(n * (lat + 1)));
`endif
    endtask

    initial begin
        int r0;
        int done_seen;
        rst       = 1'b1;
        start     = 1'b0;
        num_ch    = '0;
        num_och   = '0;
        w_ended   = 1'b0;
        pass_done = 1'b0;
        abort     = 1'b0;
        repeat (3) step();
        check_idle("reset");
        check_eq("reset_err", 32'(err), 32'd0);
        rst = 1'b0;
        step();

        // Main 3x2 layer, handshakes answered after 2 cycles.
        run_layer(3, 2, 2);

        // Zero counts are rejected with o_err; a valid start clears it.
        r0      = rise_cnt;
        num_ch  = '0;
        num_och = OCH_W'(2);
        start   = 1'b1;
        step();
        start   = 1'b0;
        check_eq("zero_ch_err", 32'({err, busy}), 32'd2);
        num_ch  = CH_W'(3);
        num_och = '0;
        start   = 1'b1;
        step();
        start   = 1'b0;
        check_eq("zero_och_err", 32'({err, busy}), 32'd2);
        repeat (3) step();
        check_eq("zero_no_req", 32'(rise_cnt - r0), 32'd0);
        start_layer(1, 1);
        check_eq("err_cleared", 32'(err), 32'd0);
        do_pass(1);
        finish_layer();

        // Synchronous reset in the middle of COMPUTE.
        start_layer(2, 1);
        w_ended = 1'b1;
        step();
        w_ended = 1'b0;
        step();
        check_eq("pre_rst_compute", 32'(compute_en), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("mid_rst");
        check_eq("mid_rst_err", 32'(err), 32'd0);
        exp_q.delete();
        run_layer(2, 1, 1);

        // Abort coinciding with pass_done on pass (0,2).
        start_layer(3, 2);
        do_pass(1);
        step();
        w_ended = 1'b1;
        step();
        w_ended = 1'b0;
        check_eq("abort_pass_idx", 32'({och_idx, ch_idx}), 32'd2);
        step();
        pass_done = 1'b1;
        abort     = 1'b1;
        step();
        pass_done = 1'b0;
        abort     = 1'b0;
        check_idle("abort");
        check_eq("abort_err", 32'(err), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) done_seen++;
        end
        check_eq("abort_no_done", 32'(done_seen), 32'd0);
        exp_q.delete();

        // Protocol violation in WLOAD, start ignored while busy.
        start_layer(2, 1);
        pass_done = 1'b1;
        step();
        pass_done = 1'b0;
        check_eq("viol_err", 32'(err), 32'd1);
        check_eq("viol_stay_wload", 32'({w_load_req, compute_en}), 32'd2);
        w_ended = 1'b1;
        step();
        w_ended = 1'b0;
        num_ch  = CH_W'(5);
        start   = 1'b1;
        step();
        start   = 1'b0;
        check_eq("busy_start_state", 32'({busy, compute_en}), 32'd3);
        check_eq("busy_start_idx", 32'({och_idx, ch_idx}), 32'd1);
        pass_done = 1'b1;
        step();
        pass_done = 1'b0;
        step();
        check_eq("viol_next_req", 32'(w_load_req), 32'd1);
        do_pass(0);
        finish_layer();
        check_eq("err_sticky", 32'(err), 32'd1);
        check_eq("viol_sb_empty", 32'(exp_q.size()), 32'd0);

        // Full-scale input channel count.
        run_layer(127, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
